digital_pattern_gen_handler: RTL
================================

Name: digital_pattern_gen_handler

Overview:
- Transmit-side counterpart of the digital capture handler.
- Receives a command carrying a 16-bit sample divider and a byte pattern, and stores the pattern in an internal buffer.
- Replays the pattern on an 8-bit parallel output, one byte per divider period, looping until stopped.
- Sits on the shared command bus beside the capture handler; used for loopback testing and for stimulus generation.

Parameters:
- DEPTH, 256: pattern buffer depth in bytes, power of two.
- CMD_START_CODE, 8'h0D: cmd_type that loads a pattern and starts replay.
- CMD_STOP_CODE, 8'h0E: cmd_type that halts replay.
- IDLE_LEVEL, 8'h00: value driven on dc_signal_out when not running.

Ports:
- clk  input  1  system clock, 60 MHz
- rst_n  input  1  asynchronous active-low reset
- cmd_start  input  1  one-cycle pulse at frame start; cmd_type is valid with it
- cmd_type  input  8  command code
- cmd_data  input  8  payload byte
- cmd_data_valid  input  1  qualifies cmd_data; one payload byte per high cycle
- cmd_done  input  1  one-cycle pulse at frame end
- dc_signal_out  output  8  generated parallel pattern, registered
- running  output  1  high while replay is active
- sample_tick  output  1  one-cycle pulse on each cycle dc_signal_out takes a new byte
- wrap_pulse  output  1  one-cycle pulse when replay returns to pattern index 0 after the last byte
- load_error  output  1  sticky flag; cleared by the next accepted start frame

Behaviour:
Reset:
- dc_signal_out=IDLE_LEVEL; running, sample_tick, wrap_pulse, load_error = 0.
- State=IDLE; divider=0; length=0. Buffer contents are not reset.

States:
- IDLE: not running, no frame in progress.
- LOAD: receiving a start frame.
- RUN: replaying the pattern.

Start frame (cmd_start with cmd_type==CMD_START_CODE):
- Accepted from any state and goes to LOAD.
- In the same cycle: running=0, dc_signal_out=IDLE_LEVEL (registered next edge), byte counter=0, load_error=0.
- Payload byte order:
  - byte0 = divider[15:8]
  - byte1 = divider[7:0]
  - bytes 2.. = pattern, written to buffer[byte_cnt-2]
- Pattern bytes beyond DEPTH are discarded and set load_error.
- cmd_data is consumed only when cmd_data_valid=1.

End of frame (cmd_done while in LOAD):
- If fewer than 3 payload bytes were received: load_error=1, go to IDLE.
- Otherwise go to RUN, with length = min(count-2, DEPTH).
- Effective divider = max(divider, 1).

RUN timing:
- On the first RUN edge: dc_signal_out=buffer[0], sample_tick=1, index=0, prescaler=0.
- Each clock the prescaler increments. When prescaler reaches eff_div-1 it clears, index advances, and the next byte is driven with a sample_tick pulse.
- Each byte is therefore held exactly eff_div cycles; with eff_div=1, a new byte is driven every clock.
- Wrap: when index==length-1 and the prescaler expires, index=0, buffer[0] is driven, and wrap_pulse and sample_tick are both high in that cycle.
- length==1: buffer[0] is re-driven every period; wrap_pulse pulses each period.

Stop (cmd_start with cmd_type==CMD_STOP_CODE):
- Takes effect on the next edge from RUN or LOAD: state=IDLE, running=0, dc_signal_out=IDLE_LEVEL.
- No payload is expected.

Other command handling:
- Other cmd_type values are ignored, and payload/cmd_done belonging to them are ignored.
- cmd_done outside LOAD is ignored.
- cmd_start and cmd_done asserted in the same cycle: cmd_start has priority.

Other rules:
- The buffer is a single-port array: LOAD writes, RUN reads. The two never overlap because LOAD forces running=0.
- Divider and prescaler are 16-bit and unsigned; the index width is $clog2(DEPTH).
- Asynchronous reset asserted mid-frame or mid-replay returns every output to its reset value immediately.

Decomposition:
- Shared package (e.g. cmd_codes_pkg):
  - command codes 8'h0B/8'h0C (capture start/stop) and 8'h0D/8'h0E (generator start/stop);
  - state enum {IDLE, LOAD, RUN};
  - DIV_W=16.
- One natural sub-module: pattern_buffer_ram (DEPTH x 8, synchronous write, registered read). The one-cycle read latency is absorbed by prefetching index+1 during each hold period. When eff_div=1 the read address must run one index ahead of the driven byte.

Test Plan:
- Start, divider=0x1770 (6000), pattern {A5,5A,FF}
  -> A5 for cycles 1..6000, then 5A for 6000 cycles, then FF, then A5 again.
  -> wrap_pulse at cycle 18001; sample_tick every 6000 cycles; running=1.
- Start, divider=0x0000, pattern {01,02,03,04}
  -> eff_div=1; output 01,02,03,04,01,... on consecutive clocks; wrap_pulse every 4th cycle.
- Stop mid-period during the 5A hold with divider 6000
  -> next edge: dc_signal_out=00, running=0, no further sample_tick.
- Start frame with only 2 payload bytes then cmd_done
  -> load_error=1, state IDLE, output 00.
  -> A subsequent valid start clears load_error.
- DEPTH=4, start frame with 6 pattern bytes
  -> load_error=1, length=4; first four bytes replayed in a loop.
- New start frame issued while running
  -> output drops to IDLE_LEVEL the cycle after cmd_start; the new pattern begins after cmd_done.
- rst_n low for 2 cycles mid-replay
  -> all outputs return to reset values asynchronously; no activity until a new start frame.

Source files
------------

// File: rtl/digital_pattern_gen_handler_pkg.sv
// Shared command codes, FSM state encoding and divider helpers for the
// command-bus handlers (capture and pattern generator).
package digital_pattern_gen_handler_pkg;

  localparam logic [7:0] CMD_CAP_START = 8'h0B;
  localparam logic [7:0] CMD_CAP_STOP  = 8'h0C;
  localparam logic [7:0] CMD_GEN_START = 8'h0D;
  localparam logic [7:0] CMD_GEN_STOP  = 8'h0E;

  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } gen_state_t;

  // A programmed divider of zero behaves like one: a new byte every clock.
  function automatic logic [DIV_W-1:0] eff_divider(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/digital_pattern_gen_handler_if.sv
// Shared command bus seen by every handler.
// Handshake: no backpressure. cmd_start and cmd_done are single-cycle pulses;
// cmd_type is valid with cmd_start; each cycle with cmd_data_valid=1 carries
// exactly one payload byte on cmd_data, and a slave must accept it that cycle.
interface digital_pattern_gen_handler_if;
  logic       cmd_start;
  logic [7:0] cmd_type;
  logic [7:0] cmd_data;
  logic       cmd_data_valid;
  logic       cmd_done;

  modport master (
    output cmd_start, cmd_type, cmd_data, cmd_data_valid, cmd_done
  );

  modport slave (
    input cmd_start, cmd_type, cmd_data, cmd_data_valid, cmd_done
  );
endinterface

// File: rtl/digital_pattern_gen_handler_pattern_buffer_ram.sv
// Single-port pattern store: synchronous write, registered read, no reset
// (contents survive reset by design).
module pattern_buffer_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/digital_pattern_gen_handler.sv
// Pattern generator: loads divider + byte pattern from the command bus, then
// replays the pattern on dc_signal_out, one byte per divider period, forever.
module digital_pattern_gen_handler
  import digital_pattern_gen_handler_pkg::*;
#(
  parameter int         DEPTH          = 256,
  parameter logic [7:0] CMD_START_CODE = CMD_GEN_START,
  parameter logic [7:0] CMD_STOP_CODE  = CMD_GEN_STOP,
  parameter logic [7:0] IDLE_LEVEL     = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst_n,
  digital_pattern_gen_handler_if.slave  cmd,
  output logic [7:0]                    dc_signal_out,
  output logic                          running,
  output logic                          sample_tick,
  output logic                          wrap_pulse,
  output logic                          load_error,
  output gen_state_t                    dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(DEPTH + 3);

  gen_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [DIV_W-1:0] r_presc, w_presc_nxt;
  logic             r_first, w_first_nxt;
  logic [7:0]       r_head;
  logic [7:0]       r_dout, w_dout_nxt;
  logic             r_running, w_running_nxt;
  logic             r_tick, w_tick_nxt;
  logic             r_wrap, w_wrap_nxt;
  logic             r_err, w_err_nxt;

  logic             w_start_gen, w_stop_gen, w_byte, w_pat_byte, w_overflow;
  logic             w_frame_end, w_frame_ok, w_expire, w_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_eff_div;
  logic [IDX_W-1:0] w_wr_addr, w_ram_addr;
  logic [7:0]       w_rdata;

  function automatic logic [IDX_W-1:0] idx_after(input logic [IDX_W-1:0] i,
                                                 input logic [LEN_W-1:0] len);
    return (LEN_W'(i) == len - LEN_W'(1)) ? '0 : i + IDX_W'(1);
  endfunction

  assign w_start_gen = cmd.cmd_start && (cmd.cmd_type == CMD_START_CODE);
  assign w_stop_gen  = cmd.cmd_start && (cmd.cmd_type == CMD_STOP_CODE);
  assign w_byte      = (r_state == ST_LOAD) && cmd.cmd_data_valid && !cmd.cmd_start;
  assign w_pat_byte  = w_byte && (r_cnt >= CNT_W'(2)) && (r_cnt < CNT_W'(DEPTH + 2));
  assign w_overflow  = w_byte && (r_cnt == CNT_W'(DEPTH + 2));
  assign w_cnt_nxt   = r_cnt + CNT_W'(w_byte && !w_overflow);
  assign w_frame_end = (r_state == ST_LOAD) && cmd.cmd_done && !cmd.cmd_start;
  assign w_frame_ok  = (w_cnt_nxt >= CNT_W'(3));
  assign w_eff_div   = eff_divider(r_div);
  assign w_expire    = (r_state == ST_RUN) && !r_first && (r_presc == w_eff_div - DIV_W'(1));
  assign w_last      = (LEN_W'(r_idx) == r_len - LEN_W'(1));
  assign w_wr_addr   = IDX_W'(r_cnt - CNT_W'(2));

  // Index 0 always comes from r_head, so the RAM only has to supply the byte
  // after the one about to be driven; addressing from w_idx_nxt keeps that
  // prefetch one index ahead even when a new byte goes out every clock.
  assign w_ram_addr = (r_state == ST_LOAD) ? w_wr_addr : idx_after(w_idx_nxt, r_len);

  pattern_buffer_ram #(.DEPTH(DEPTH), .AW(IDX_W)) u_ram (
    .i_clk   (clk),
    .i_we    (w_pat_byte),
    .i_addr  (w_ram_addr),
    .i_wdata (cmd.cmd_data),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start_gen)                            w_state_nxt = ST_LOAD;
    else if (w_stop_gen && r_state != ST_IDLE)  w_state_nxt = ST_IDLE;
    else if (w_frame_end)                       w_state_nxt = w_frame_ok ? ST_RUN : ST_IDLE;
  end

  always_comb begin
    w_dout_nxt    = r_dout;
    w_tick_nxt    = 1'b0;
    w_wrap_nxt    = 1'b0;
    w_err_nxt     = r_err;
    w_idx_nxt     = r_idx;
    w_presc_nxt   = r_presc;
    w_first_nxt   = r_first;
    w_len_nxt     = r_len;
    w_running_nxt = (w_state_nxt == ST_RUN);
    if (w_start_gen) begin
      w_dout_nxt = IDLE_LEVEL;
      w_err_nxt  = 1'b0;
    end else begin
      if (w_overflow || (w_frame_end && !w_frame_ok)) w_err_nxt = 1'b1;
      if (w_state_nxt == ST_IDLE) begin
        w_dout_nxt = IDLE_LEVEL;
      end else if (r_state == ST_LOAD && w_state_nxt == ST_RUN) begin
        // One priming cycle follows so the RAM can fetch index 1.
        w_first_nxt = 1'b1;
        w_idx_nxt   = '0;
        w_presc_nxt = '0;
        w_len_nxt   = LEN_W'(w_cnt_nxt - CNT_W'(2));
      end else if (r_state == ST_RUN) begin
        if (r_first) begin
          w_first_nxt = 1'b0;
          w_dout_nxt  = r_head;
          w_tick_nxt  = 1'b1;
          w_idx_nxt   = '0;
          w_presc_nxt = '0;
        end else if (w_expire) begin
          w_presc_nxt = '0;
          w_tick_nxt  = 1'b1;
          if (w_last) begin
            w_idx_nxt  = '0;
            w_dout_nxt = r_head;
            w_wrap_nxt = 1'b1;
          end else begin
            w_idx_nxt  = r_idx + IDX_W'(1);
            w_dout_nxt = w_rdata;
          end
        end else begin
          w_presc_nxt = r_presc + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_div     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_presc   <= '0;
      r_first   <= 1'b0;
      r_head    <= '0;
      r_dout    <= IDLE_LEVEL;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_start_gen) r_cnt <= '0;
      else             r_cnt <= w_cnt_nxt;
      if (w_byte && r_cnt == CNT_W'(0)) r_div[15:8] <= cmd.cmd_data;
      if (w_byte && r_cnt == CNT_W'(1)) r_div[7:0]  <= cmd.cmd_data;
      if (w_pat_byte && r_cnt == CNT_W'(2)) r_head  <= cmd.cmd_data;
      r_len     <= w_len_nxt;
      r_idx     <= w_idx_nxt;
      r_presc   <= w_presc_nxt;
      r_first   <= w_first_nxt;
      r_dout    <= w_dout_nxt;
      r_running <= w_running_nxt;
      r_tick    <= w_tick_nxt;
      r_wrap    <= w_wrap_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign dc_signal_out = r_dout;
  assign running       = r_running;
  assign sample_tick   = r_tick;
  assign wrap_pulse    = r_wrap;
  assign load_error    = r_err;
  assign dbg_state     = r_state;

endmodule
